// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes and FSM state encoding for the serial shifter
package shift_pkg;

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_ASHR = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit-position shift/rotate of d according to op
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SHL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SHR:  q = {1'b0, d[WIDTH-1:1]};
            OP_ASHR: q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle shifter, one bit position per clock
module serial_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_d;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_d)
    );

    assign accept   = in_valid && in_ready;
    assign out_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_SHL;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q <= in_data;
                cnt_q  <= in_amt;
                op_q   <= in_op;
            end else if (state == ST_SHIFT) begin
                data_q <= step_d;
                cnt_q  <= cnt_q - AMT_W'(1);
            end
        end
    end

    // SHIFT is only entered with a nonzero count, so count==1 marks the last step
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (in_amt == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (cnt_q == AMT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

endmodule
